lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter WIDTH, default 4: LFSR width in bits, matching the loadable LFSR counter under check.
REQ-002 Parameter LOCK_CNT, default 3: consecutive correct samples needed to declare lock (range 1..15).
REQ-003 Parameter MISS_MAX, default 2: consecutive mismatches in lock that force re-acquisition (range 1..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cen  input  1  sample valid: count is sampled only when cen=1.
REQ-007 load_n  input  1  active-low notice that the counter is reloading; the sequence restarts from an arbitrary value.
REQ-008 count  input  WIDTH  observed LFSR counter value.
REQ-009 locked  output  1  checker is tracking a verified sequence.
REQ-010 err  output  1  one-cycle pulse per mismatched sample while locked.
REQ-011 err_cnt  output  8  total mismatches since reset, saturating at 255.
REQ-012 lockup  output  1  last sampled count was all-ones, the illegal XNOR lock-up state.
REQ-013 expected  output  WIDTH  value the checker predicts for the next sample.

Function
REQ-014 Next-state rule: next = {cur[WIDTH-2:0], fb}, where fb = XNOR of the package tap bits; for WIDTH=4, taps are bits 3 and 2, giving sequence 0000,0001,0011,0111,1110,1101,1011,0110,...
REQ-015 The FSM has states SEED, VERIFY and TRACK; reset enters SEED.
REQ-016 SEED, cen=1: expected <= next(count), match counter <= 0, go to VERIFY.
REQ-017 VERIFY, cen=1 and count==expected: match counter increments and expected <= next(expected); when the counter reaches LOCK_CNT, go to TRACK and set locked=1.
REQ-018 VERIFY, cen=1 and count!=expected: reseed (expected <= next(count), match counter <= 0), stay in VERIFY, no err.
REQ-019 TRACK, cen=1: expected <= next(expected) (flywheel, never reseeded from count); on match, miss counter <= 0.
REQ-020 TRACK, cen=1 and mismatch: err=1 for one cycle, err_cnt increments (saturating at 255) and the miss counter increments; on reaching MISS_MAX, go to SEED with locked=0.
REQ-021 cen=0: state, counters and expected hold, and err=0.
REQ-022 Priority is rst > load_n=0 > cen; load_n=0 forces SEED and locked=0 without err and without changing err_cnt.
REQ-023 load_n=0 together with cen=1 is treated as a load only; that sample is not compared.
REQ-024 lockup updates on every cen=1 sample in every state, and an all-ones sample is also compared like any other value.
REQ-025 All outputs are registered; err, locked and lockup reflect the sample taken at the previous rising edge (latency 1 cycle).
REQ-026 Timing is unchanged for any cen duty cycle, including cen held continuously at 1.

Reset
REQ-027 On rst=1 at a rising edge: state=SEED, locked=0, err=0, err_cnt=0, lockup=0, expected=0, and both match and miss counters=0.
REQ-028 Reset asserted mid-lock or mid-verify discards all progress, with no err pulse.
REQ-029 No output depends combinationally on rst.

Structure
REQ-030 A shared package lfsr_pkg holds the tap-mask constant per WIDTH, the next-state function, the FSM state enumeration and the all-ones lockup constant; the LFSR counter uses the same package.
REQ-031 The next-state logic is one sub-module, lfsr_next (combinational, WIDTH-parameterised), instantiated twice: for count and for expected.
REQ-032 The FSM, the saturating counters and the output registers stay in lfsr_checker.

Verification
REQ-033 After reset, drive count 0000,0001,0011,0111 with cen=1 -> locked=1 one cycle after the 4th sample, err never asserted.
REQ-034 While locked, drive 1010 where 1110 is expected, then resume the correct sequence -> one err pulse, err_cnt=1, locked stays 1.
REQ-035 While locked, drive two consecutive wrong values -> err_cnt=2, locked=0 one cycle after the 2nd, and the FSM is in SEED.
REQ-036 While locked, assert load_n=0 with count=1011, then continue 0110,1100,... -> no err, locked drops, then relocks after LOCK_CNT matches.
REQ-037 Drive count=1111 with cen=1 -> lockup=1 the next cycle; apply rst=1 mid-lock -> all outputs at reset values the next cycle.
REQ-038 Force 300 mismatches while locked, relocking in between -> err_cnt saturates at 255.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR LFSR counter and its checker: taps, step function,
// checker FSM states and the lock-up pattern.
package lfsr_pkg;

   localparam int unsigned MAX_WIDTH = 32;

   // All-ones is the one state an XNOR LFSR can never leave.
   localparam logic [MAX_WIDTH-1:0] LOCKUP_ONES = '1;

   typedef enum logic [1:0] {
      StSeed,
      StVerify,
      StTrack
   } chk_state_e;

   function automatic logic [MAX_WIDTH-1:0] tap_mask(int unsigned width);
      case (width)
         2:       return 32'h0000_0003;
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         default: return 32'h0000_0003 << (width - 2);
      endcase
   endfunction

   // Bits at and above 'width' are don't-care; callers truncate the result.
   function automatic logic [MAX_WIDTH-1:0] lfsr_step(logic [MAX_WIDTH-1:0] cur,
                                                      int unsigned width);
      logic fb;
      fb = ~^(cur & tap_mask(width));
      return (cur << 1) | {31'b0, fb};
   endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state of a WIDTH-bit XNOR LFSR.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   assign nxt = WIDTH'(lfsr_step(32'(cur), WIDTH));

endmodule

// File: rtl/lfsr_checker.sv
// Sequence checker for an XNOR LFSR counter: acquires the sequence, then flywheels on its own
// prediction and counts mismatches.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned MISS_MAX = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             load_n,
   input  logic [WIDTH-1:0] count,
   output logic             locked,
   output logic             err,
   output logic [7:0]       err_cnt,
   output logic             lockup,
   output logic [WIDTH-1:0] expected
);

   localparam logic [WIDTH-1:0] Ones = LOCKUP_ONES[WIDTH-1:0];

   chk_state_e       state_q;
   logic [WIDTH-1:0] expected_q;
   logic [WIDTH-1:0] next_count;
   logic [WIDTH-1:0] next_exp;
   logic [3:0]       match_q;
   logic [3:0]       miss_q;
   logic             locked_q;
   logic             err_q;
   logic [7:0]       err_cnt_q;
   logic             lockup_q;

   lfsr_next #(.WIDTH(WIDTH)) u_next_count (
      .cur (count),
      .nxt (next_count)
   );

   lfsr_next #(.WIDTH(WIDTH)) u_next_exp (
      .cur (expected_q),
      .nxt (next_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StSeed;
         expected_q <= '0;
         match_q    <= '0;
         miss_q     <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         lockup_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (cen) begin
            lockup_q <= (count == Ones);
         end
         if (!load_n) begin
            // Reload restarts anywhere; the sample alongside it is never compared.
            state_q  <= StSeed;
            locked_q <= 1'b0;
            match_q  <= '0;
            miss_q   <= '0;
         end else if (cen) begin
            case (state_q)
               StSeed: begin
                  expected_q <= next_count;
                  match_q    <= '0;
                  state_q    <= StVerify;
               end
               StVerify: begin
                  if (count == expected_q) begin
                     match_q    <= match_q + 4'd1;
                     expected_q <= next_exp;
                     if (match_q + 4'd1 == 4'(LOCK_CNT)) begin
                        state_q  <= StTrack;
                        locked_q <= 1'b1;
                        miss_q   <= '0;
                     end
                  end else begin
                     expected_q <= next_count;
                     match_q    <= '0;
                  end
               end
               StTrack: begin
                  expected_q <= next_exp;
                  if (count == expected_q) begin
                     miss_q <= '0;
                  end else begin
                     err_q  <= 1'b1;
                     miss_q <= miss_q + 4'd1;
                     if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                     end
                     if (miss_q + 4'd1 == 4'(MISS_MAX)) begin
                        state_q  <= StSeed;
                        locked_q <= 1'b0;
                     end
                  end
               end
               default: state_q <= StSeed;
            endcase
         end
      end
   end

   assign locked   = locked_q;
   assign err      = err_q;
   assign err_cnt  = err_cnt_q;
   assign lockup   = lockup_q;
   assign expected = expected_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized bench for lfsr_checker with a table-driven reference model and literal anchors.
module tb_lfsr_checker;

   localparam int LOCK_CNT = 3;
   localparam int MISS_MAX = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b0;
   logic       load_n = 1'b1;
   logic [3:0] count = 4'h0;
   logic       locked;
   logic       err;
   logic [7:0] err_cnt;
   logic       lockup;
   logic [3:0] expected;

   int checks = 0;
   int errors = 0;

   // Full period of the 4-bit XNOR LFSR; 1111 is the stuck state outside it.
   int seq [15] = '{0, 1, 3, 7, 14, 13, 11, 6, 12, 9, 2, 5, 10, 4, 8};

   // Model state: mode 0 = acquiring seed, 1 = verifying, 2 = tracking.
   int         m_mode = 0;
   logic [3:0] m_exp = 0;
   int         m_match = 0;
   int         m_miss = 0;
   int         m_errcnt = 0;
   bit         m_locked = 0;
   bit         m_err = 0;
   bit         m_lockup = 0;

   lfsr_checker #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) dut (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .load_n   (load_n),
      .count    (count),
      .locked   (locked),
      .err      (err),
      .err_cnt  (err_cnt),
      .lockup   (lockup),
      .expected (expected)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ref_next(logic [3:0] v);
      if (v == 4'hF) return 4'hF;
      for (int i = 0; i < 15; i++) begin
         if (seq[i] == int'(v)) return 4'(seq[(i + 1) % 15]);
      end
      return 4'hF;
   endfunction

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void model(bit r, bit ln, bit c, logic [3:0] v);
      if (r) begin
         m_mode = 0; m_exp = 0; m_match = 0; m_miss = 0;
         m_errcnt = 0; m_locked = 0; m_err = 0; m_lockup = 0;
         return;
      end
      m_err = 0;
      if (c) m_lockup = (v == 4'hF);
      if (!ln) begin
         m_mode = 0; m_locked = 0; m_match = 0; m_miss = 0;
      end else if (c) begin
         if (m_mode == 0) begin
            m_exp = ref_next(v); m_match = 0; m_mode = 1;
         end else if (m_mode == 1) begin
            if (v == m_exp) begin
               m_match++;
               m_exp = ref_next(m_exp);
               if (m_match == LOCK_CNT) begin
                  m_mode = 2; m_locked = 1; m_miss = 0;
               end
            end else begin
               m_exp = ref_next(v); m_match = 0;
            end
         end else begin
            if (v == m_exp) begin
               m_miss = 0;
            end else begin
               m_err = 1;
               if (m_errcnt < 255) m_errcnt++;
               m_miss++;
               if (m_miss == MISS_MAX) begin
                  m_mode = 0; m_locked = 0;
               end
            end
            m_exp = ref_next(m_exp);
         end
      end
   endfunction

   // One clock: apply inputs, advance the model on the edge, compare 1 time unit later.
   task automatic step(bit r, bit ln, bit c, logic [3:0] v);
      rst = r; load_n = ln; cen = c; count = v;
      @(posedge clk);
      model(r, ln, c, v);
      #1;
      chk("locked", int'(locked), int'(m_locked));
      chk("err", int'(err), int'(m_err));
      chk("err_cnt", int'(err_cnt), m_errcnt);
      chk("lockup", int'(lockup), int'(m_lockup));
      chk("expected", int'(expected), int'(m_exp));
   endtask

   task automatic sample(logic [3:0] v);
      step(1'b0, 1'b1, 1'b1, v);
   endtask

   initial begin
      logic [3:0] true_val;
      bit r, ln, c;
      logic [3:0] v;

      step(1'b1, 1'b1, 1'b0, 4'h0);
      chk("reset_locked", int'(locked), 0);
      chk("reset_err_cnt", int'(err_cnt), 0);
      chk("reset_expected", int'(expected), 0);

      // Acquire from 0000.
      sample(4'b0000); sample(4'b0001); sample(4'b0011);
      chk("not_yet_locked", int'(locked), 0);
      sample(4'b0111);
      chk("locked_after_4", int'(locked), 1);
      chk("exp_after_lock", int'(expected), 4'b1110);

      // Single wrong value, then resume.
      sample(4'b1010);
      chk("err_pulse", int'(err), 1);
      chk("err_cnt_1", int'(err_cnt), 1);
      chk("still_locked", int'(locked), 1);
      sample(4'b1101);
      chk("err_cleared", int'(err), 0);
      sample(4'b1011);

      // Two consecutive wrong values drop lock.
      sample(4'b0000);
      sample(4'b0000);
      chk("err_cnt_3", int'(err_cnt), 3);
      chk("lock_lost", int'(locked), 0);
      sample(4'b0101);
      chk("reseeded_exp", int'(expected), 4'b1010);
      sample(4'b1010); sample(4'b0100); sample(4'b1000);
      chk("relocked", int'(locked), 1);

      // Reload while locked.
      step(1'b0, 1'b0, 1'b1, 4'b1011);
      chk("load_unlocks", int'(locked), 0);
      chk("load_no_err", int'(err), 0);
      chk("load_err_cnt", int'(err_cnt), 3);
      sample(4'b0110); sample(4'b1100); sample(4'b1001); sample(4'b0010);
      chk("relock_after_load", int'(locked), 1);
      chk("exp_after_relock", int'(expected), 4'b0101);

      // Lock-up pattern, then reset mid-lock.
      sample(4'b0101);
      sample(4'b1111);
      chk("lockup_set", int'(lockup), 1);
      chk("lockup_err_cnt", int'(err_cnt), 4);
      step(1'b1, 1'b1, 1'b1, 4'b1010);
      chk("rst_locked", int'(locked), 0);
      chk("rst_lockup", int'(lockup), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_err", int'(err), 0);

      // 300 mismatches, relocking between pairs.
      for (int k = 0; k < 150; k++) begin
         sample(4'b0000); sample(4'b0001); sample(4'b0011); sample(4'b0111);
         sample(4'b0000); sample(4'b0000);
      end
      chk("err_cnt_saturated", int'(err_cnt), 255);

      // Random traffic: a true counter with reloads, glitches, gaps and rare resets.
      true_val = 4'($urandom_range(0, 14));
      for (int n = 0; n < 4000; n++) begin
         r  = ($urandom_range(0, 499) == 0);
         ln = ($urandom_range(0, 39) != 0);
         c  = ($urandom_range(0, 3) != 0) || (n >= 3000);
         if (!ln) true_val = 4'($urandom_range(0, 15));
         v = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(0, 15)) : true_val;
         step(r, ln, c, v);
         if (c && ln) true_val = ref_next(true_val);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
